// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot engine: signed Q3.21 fixed point,
// escape radius and the iteration FSM encoding.
package mandel_pkg;

  localparam int FP_WIDTH = 25;
  localparam int FP_FRAC  = 21;

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  localparam fp_t ESCAPE_R2 = fp_t'(4 << FP_FRAC);

  typedef enum logic [2:0] {
    IDLE,
    MXX,
    MYY,
    MXY,
    CHECK,
    UPDATE
  } state_t;

  // True when a two-guard-bit result can be narrowed to fp_t without loss.
  function automatic logic fits_fp(input logic signed [FP_WIDTH+1:0] v);
    return (v[FP_WIDTH+1:FP_WIDTH-1] == 3'b000) || (v[FP_WIDTH+1:FP_WIDTH-1] == 3'b111);
  endfunction

endpackage

// File: rtl/mul.sv
// Pipelined signed fixed-point multiplier: val = (a*b) >>> FP_FRAC, flooring,
// with ovf when the product leaves the fp_t range. done follows start by 4 cycles.
module mul
  import mandel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  fp_t  a,
  input  fp_t  b,
  output logic done,
  output fp_t  val,
  output logic ovf
);

  logic [2:0]                    vld;
  fp_t                           a_q;
  fp_t                           b_q;
  logic signed [2*FP_WIDTH-1:0]  prod_q;
  logic [FP_WIDTH-FP_FRAC:0]     top_bits;
  logic                          unused_lsb;

  assign top_bits   = prod_q[2*FP_WIDTH-1:FP_WIDTH+FP_FRAC-1];
  assign unused_lsb = ^prod_q[FP_FRAC-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      done   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      val    <= '0;
      ovf    <= 1'b0;
    end else begin
      vld  <= {vld[1:0], start};
      done <= vld[2];
      if (start) begin
        a_q <= a;
        b_q <= b;
      end
      if (vld[0]) prod_q <= a_q * b_q;
      if (vld[1]) begin
        val <= prod_q[FP_WIDTH+FP_FRAC-1:FP_FRAC];
        ovf <= !((top_bits == '0) || (top_bits == '1));
      end
    end
  end

endmodule

// File: rtl/mandel_iter.sv
// Per-pixel Mandelbrot iteration engine sharing one mul for x*x, y*y and x*y.
// Optional MANDEL_PERIODICITY_EN adds a periodicity early-out (same results, lower latency).
module mandel_iter
  import mandel_pkg::*;
#(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  fp_t               cx,
  input  fp_t               cy,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter,
  output logic              escaped
);

  state_t state, state_next;

  fp_t               cx_q, cy_q, x, y, xx, yy, xy;
  logic [ITER_W-1:0] max_q, n, n_inc;
  logic              ovf_acc, issued;

  logic              mul_start, mul_done, mul_ovf;
  fp_t               mul_a, mul_b, mul_val;

  logic signed [FP_WIDTH:0]   mag2;
  logic signed [FP_WIDTH+1:0] xn, yn;
  logic                       exit_now, exit_esc;
  logic [ITER_W-1:0]          exit_iter;

`ifdef MANDEL_PERIODICITY_EN
  fp_t  snap_x, snap_y;
  logic snap_valid, snap_take;
  assign snap_take = (n_inc & (n_inc - ITER_W'(1))) == '0;
`endif

  assign n_inc = n + ITER_W'(1);
  assign mag2  = (FP_WIDTH+1)'(xx) + (FP_WIDTH+1)'(yy);
  assign xn    = (FP_WIDTH+2)'(xx) - (FP_WIDTH+2)'(yy) + (FP_WIDTH+2)'(cx_q);
  assign yn    = ((FP_WIDTH+2)'(xy) <<< 1) + (FP_WIDTH+2)'(cy_q);

  assign mul_a = (state == MYY) ? y : x;
  assign mul_b = (state == MXX) ? x : y;

  mul u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .val   (mul_val),
    .ovf   (mul_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Each multiply state issues one mul start and advances only on mul done.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    exit_now   = 1'b0;
    exit_esc   = 1'b0;
    exit_iter  = n;
    case (state)
      IDLE: if (start) state_next = MXX;
      MXX: begin
        mul_start = !issued;
        if (mul_done) state_next = MYY;
      end
      MYY: begin
        mul_start = !issued;
        if (mul_done) state_next = MXY;
      end
      MXY: begin
        mul_start = !issued;
        if (mul_done) state_next = CHECK;
      end
      CHECK: begin
        if (ovf_acc || (mag2 > (FP_WIDTH+1)'(ESCAPE_R2))) begin
          exit_now = 1'b1;
          exit_esc = 1'b1;
        end else if (n == max_q) begin
          exit_now = 1'b1;
        end else begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        if (!fits_fp(xn) || !fits_fp(yn)) begin
          exit_now  = 1'b1;
          exit_esc  = 1'b1;
          exit_iter = n_inc;
`ifdef MANDEL_PERIODICITY_EN
        end else if (snap_valid && (xn[FP_WIDTH-1:0] == snap_x) && (yn[FP_WIDTH-1:0] == snap_y)) begin
          exit_now  = 1'b1;
          exit_iter = max_q;
`endif
        end else begin
          state_next = MXX;
        end
      end
      default: state_next = IDLE;
    endcase
    if (exit_now) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q    <= '0;
      cy_q    <= '0;
      max_q   <= '0;
      x       <= '0;
      y       <= '0;
      n       <= '0;
      xx      <= '0;
      yy      <= '0;
      xy      <= '0;
      ovf_acc <= 1'b0;
      issued  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      iter    <= '0;
      escaped <= 1'b0;
`ifdef MANDEL_PERIODICITY_EN
      snap_x     <= '0;
      snap_y     <= '0;
      snap_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        cx_q    <= cx;
        cy_q    <= cy;
        max_q   <= max_iter;
        x       <= '0;
        y       <= '0;
        n       <= '0;
        ovf_acc <= 1'b0;
        issued  <= 1'b0;
        busy    <= 1'b1;
        iter    <= '0;
        escaped <= 1'b0;
`ifdef MANDEL_PERIODICITY_EN
        snap_valid <= 1'b0;
`endif
      end
      if (mul_start) issued <= 1'b1;
      if (mul_done) begin
        issued  <= 1'b0;
        ovf_acc <= ovf_acc | mul_ovf;
        case (state)
          MXX:     xx <= mul_val;
          MYY:     yy <= mul_val;
          MXY:     xy <= mul_val;
          default: ;
        endcase
      end
      if (state == UPDATE && !exit_now) begin
        x       <= xn[FP_WIDTH-1:0];
        y       <= yn[FP_WIDTH-1:0];
        n       <= n_inc;
        ovf_acc <= 1'b0;
`ifdef MANDEL_PERIODICITY_EN
        if (snap_take) begin
          snap_x     <= xn[FP_WIDTH-1:0];
          snap_y     <= yn[FP_WIDTH-1:0];
          snap_valid <= 1'b1;
        end
`endif
      end
      if (exit_now) begin
        done    <= 1'b1;
        busy    <= 1'b0;
        iter    <= exit_iter;
        escaped <= exit_esc;
      end
    end
  end

endmodule

// File: tb/tb_mandel_iter.sv
// Bench for mandel_iter: directed and random pixels scored against a plain-arithmetic
// reference of the escape-time iteration.
module tb_mandel_iter;
  import mandel_pkg::*;

  localparam int ITER_W = 16;
  localparam longint ONE    = 64'sd1 << FP_FRAC;
  localparam longint FP_MAX = (64'sd1 << (FP_WIDTH-1)) - 1;
  localparam longint FP_MIN = -(64'sd1 << (FP_WIDTH-1));
  localparam int C79 = 16567501;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  fp_t               cx, cy;
  logic [ITER_W-1:0] max_iter;
  logic              busy, done, escaped;
  logic [ITER_W-1:0] iter;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [ITER_W:0] exp_q[$];

  mandel_iter #(.ITER_W(ITER_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cx       (cx),
    .cy       (cy),
    .max_iter (max_iter),
    .busy     (busy),
    .done     (done),
    .iter     (iter),
    .escaped  (escaped)
  );

  always #5 clk = ~clk;

  function automatic bit in_fp(input longint v);
    return (v >= FP_MIN) && (v <= FP_MAX);
  endfunction

  // Escape-time iteration written straight from the arithmetic rules.
  function automatic logic [ITER_W:0] ref_model(input longint c_re, input longint c_im, input int mx);
    longint zr = 0, zi = 0, rr, ii, ri, nr, ni;
    int n = 0;
    while (1) begin
      rr = (zr * zr) >>> FP_FRAC;
      ii = (zi * zi) >>> FP_FRAC;
      ri = (zr * zi) >>> FP_FRAC;
      if (!in_fp(rr) || !in_fp(ii) || !in_fp(ri)) return {1'b1, ITER_W'(n)};
      if (rr + ii > 4 * ONE) return {1'b1, ITER_W'(n)};
      if (n == mx) return {1'b0, ITER_W'(n)};
      nr = rr - ii + c_re;
      ni = 2 * ri + c_im;
      if (!in_fp(nr) || !in_fp(ni)) return {1'b1, ITER_W'(n + 1)};
      zr = nr;
      zi = ni;
      n++;
    end
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every done pops one expected {escaped, iter}.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done iter %0d escaped %0d", iter, escaped);
      end else begin
        logic [ITER_W:0] e;
        e = exp_q.pop_front();
        if ({escaped, iter} != e) begin
          errors++;
          $display("FAIL result got iter %0d esc %0d expected iter %0d esc %0d",
                   iter, escaped, e[ITER_W-1:0], e[ITER_W]);
        end
      end
      checks++;
      if (busy || prev_done) begin
        errors++;
        $display("FAIL done_shape busy %0d prev_done %0d expected 0 0", busy, prev_done);
      end
    end
    prev_done = done;
  end

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!done && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      chk("timeout", lat, -1);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic run_pixel(input fp_t c_re, input fp_t c_im, input int mx, input int budget,
                           output int lat);
    exp_q.push_back(ref_model(c_re, c_im, mx));
    @(posedge clk); #1;
    cx = c_re;
    cy = c_im;
    max_iter = ITER_W'(mx);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_done(budget, lat);
  endtask

  initial begin
    int lat, d0;
    fp_t rc, ri;
    int rm;
    rst = 1'b1;
    start = 1'b0;
    cx = '0;
    cy = '0;
    max_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_iter", iter, 0);
    chk("reset_escaped", escaped, 0);
    rst = 1'b0;

    run_pixel('0, '0, 255, 20000, lat);
    run_pixel(fp_t'(2 * ONE), '0, 255, 20000, lat);
    run_pixel(fp_t'(ONE), '0, 255, 20000, lat);
    run_pixel(fp_t'(-2 * ONE), '0, 1000, 20000, lat);
    run_pixel(fp_t'(C79), '0, 255, 20000, lat);
    run_pixel('0, '0, 0, 100, lat);
    chk("max_iter0_latency_ok", (lat >= 15 && lat <= 20), 1);

    // Reset while the second iteration's x*y multiply is in flight.
    @(posedge clk); #1;
    cx = fp_t'(C79);
    cy = '0;
    max_iter = 16'd255;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_iter", iter, 0);
    chk("midrst_escaped", escaped, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, d0);
    run_pixel(fp_t'(C79), '0, 255, 20000, lat);

    // start and cx disturbed while busy must not alter the running pixel.
    exp_q.push_back(ref_model(ONE, 0, 255));
    @(posedge clk); #1;
    cx = fp_t'(ONE);
    cy = '0;
    max_iter = 16'd255;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    cx = fp_t'(C79);
    max_iter = '0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    wait_done(2000, lat);
    repeat (60) @(posedge clk);
    #1;
    chk("busy_start_single_done", done_cnt, d0 + 1);

    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 3) begin
        rc = fp_t'(int'($urandom_range(0, 33554431)) - 16777216);
        ri = fp_t'(int'($urandom_range(0, 33554431)) - 16777216);
      end else begin
        rc = fp_t'(int'($urandom_range(0, 5 * 2097152)) - 3 * 2097152);
        ri = fp_t'(int'($urandom_range(0, 4 * 2097152)) - 2 * 2097152);
      end
      rm = int'($urandom_range(0, 50));
      run_pixel(rc, ri, rm, 17 * (rm + 1) + 50, lat);
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
